// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//
// Multi-cycle execution unit for the RV32M instructions (MUL, MULH, MULHSU,
// MULHU, DIV, DIVU, REM, REMU). It sits beside the single-cycle ALU in EX,
// accepts one op per start pulse and holds the pipeline in stall while it
// iterates. The multiply is radix-2 shift-add and the divide is restoring.
// Both work on operand magnitudes and apply the sign at the end. The
// finished result and rd tag are presented for one cycle.
//
// Parameters
//   XLEN      operand/result width; iterative ops take XLEN iterations
//   FAST_MUL  1 = multiplies use a combinational product and finish in the
//             cycle after accept
//
// Ports
//   clk           clock, rising edge
//   reset_n       asynchronous active-low reset
//   start         EX holds an M-op with valid operands
//   alu_select    5-bit op code (00100..01011 are the M-ops)
//   operand_a     rs1 value
//   operand_b     rs2 value
//   rd_in         destination register tag
//   flush         abort the in-flight op (branch/jump redirect)
//   stall         freeze IF/ID/EX registers
//   busy          sequencer is not idle
//   result_valid  result/rd_out valid this cycle
//   result        op result (holds the last completed value otherwise)
//   rd_out        rd tag of the result (holds the last completed tag)
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int XLEN     = 32,
    parameter int FAST_MUL = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [4:0]        alu_select,
    input  logic [XLEN-1:0]   operand_a,
    input  logic [XLEN-1:0]   operand_b,
    input  logic [4:0]        rd_in,
    input  logic              flush,
    output logic              stall,
    output logic              busy,
    output logic              result_valid,
    output logic [XLEN-1:0]   result,
    output logic [4:0]        rd_out
);

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [CW-1:0]   LAST_COUNT = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG   = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [CW-1:0]     counter;

    // Latched operation and operand state
    logic [1:0]        op_code;
    logic              op_is_mul;
    logic              neg_main;
    logic              neg_rem;
    logic              special_r;
    logic [XLEN-1:0]   special_value_r;
    logic [XLEN-1:0]   opb;
    logic [XLEN-1:0]   acc_hi;
    logic [XLEN-1:0]   acc_lo;
    logic [4:0]        rd_reg;

    // Values presented outside the DONE cycle
    logic [XLEN-1:0]   result_hold;
    logic [4:0]        rd_hold;

    // ------------------------------------------------------------------
    // Decode of the incoming op
    // ------------------------------------------------------------------
    logic              sel_is_mul;
    logic              sel_is_div;
    logic              is_m_op;
    logic              accept;
    logic              a_signed;
    logic              b_signed;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              b_zero;
    logic              div_overflow;
    logic              is_special;
    logic [XLEN-1:0]   special_value;
    logic [2*XLEN-1:0] fast_product;
    logic              finish_now;

    // Multiply codes are 001xx, divide codes are 010xx. Within the multiply
    // group: 00 MUL, 01 MULH, 10 MULHU, 11 MULHSU. Within the divide group:
    // 00 DIV, 01 DIVU, 10 REM, 11 REMU.
    assign sel_is_mul = (alu_select[4:2] == 3'b001);
    assign sel_is_div = (alu_select[4:2] == 3'b010);
    assign is_m_op    = sel_is_mul | sel_is_div;
    assign accept     = (state == ST_IDLE) & start & is_m_op & ~flush;

    always_comb begin
        if (sel_is_mul) begin
            a_signed = (alu_select[1:0] != 2'b10);
            b_signed = ~alu_select[1];
        end else begin
            a_signed = ~alu_select[0];
            b_signed = ~alu_select[0];
        end
    end

    assign a_neg = a_signed & operand_a[XLEN-1];
    assign b_neg = b_signed & operand_b[XLEN-1];
    assign mag_a = a_neg ? (~operand_a + 1'b1) : operand_a;
    assign mag_b = b_neg ? (~operand_b + 1'b1) : operand_b;

    // Divide-by-zero and the signed overflow case finish without iterating.
    assign b_zero       = (operand_b == '0);
    assign div_overflow = ~alu_select[0] & (operand_a == MOST_NEG) & (operand_b == '1);
    assign is_special   = sel_is_div & (b_zero | div_overflow);

    always_comb begin
        if (b_zero) begin
            special_value = alu_select[1] ? operand_a : '1;
        end else begin
            special_value = alu_select[1] ? '0 : MOST_NEG;
        end
    end

    assign fast_product = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
    assign finish_now   = is_special | (sel_is_mul & (FAST_MUL != 0));

    // ------------------------------------------------------------------
    // One iteration step. Multiply and divide share the acc_hi/acc_lo pair:
    // for multiply acc_lo starts as the multiplier and is shifted out to the
    // right while the product fills in from the top; for divide acc_lo
    // starts as the dividend, is shifted out to the left into the partial
    // remainder in acc_hi, and quotient bits fill in at the bottom.
    // ------------------------------------------------------------------
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shifted;
    logic [XLEN+1:0]   div_diff;
    logic [XLEN-1:0]   hi_step;
    logic [XLEN-1:0]   lo_step;

    always_comb begin
        mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
        div_shifted = {acc_hi, acc_lo[XLEN-1]};
        div_diff    = {1'b0, div_shifted} - {2'b00, opb};
        if (op_is_mul) begin
            hi_step = mul_sum[XLEN:1];
            lo_step = {mul_sum[0], acc_lo[XLEN-1:1]};
        end else begin
            // The top bit of div_diff is the borrow: restore on borrow.
            hi_step = div_diff[XLEN+1] ? div_shifted[XLEN-1:0] : div_diff[XLEN-1:0];
            lo_step = {acc_lo[XLEN-2:0], ~div_diff[XLEN+1]};
        end
    end

    // ------------------------------------------------------------------
    // Sign fix-up and result selection from the final accumulator
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] product_signed;
    logic [XLEN-1:0]   quotient_signed;
    logic [XLEN-1:0]   remainder_signed;
    logic [XLEN-1:0]   final_value;

    always_comb begin
        product_signed   = neg_main ? (~{acc_hi, acc_lo} + 1'b1) : {acc_hi, acc_lo};
        quotient_signed  = neg_main ? (~acc_lo + 1'b1) : acc_lo;
        remainder_signed = neg_rem  ? (~acc_hi + 1'b1) : acc_hi;
        if (special_r) begin
            final_value = special_value_r;
        end else if (op_is_mul) begin
            final_value = (op_code == 2'b00) ? product_signed[XLEN-1:0]
                                             : product_signed[2*XLEN-1:XLEN];
        end else begin
            final_value = op_code[1] ? remainder_signed : quotient_signed;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; flush overrides everything
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = finish_now ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (counter == LAST_COUNT) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (flush) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter         <= '0;
            op_code         <= '0;
            op_is_mul       <= 1'b0;
            neg_main        <= 1'b0;
            neg_rem         <= 1'b0;
            special_r       <= 1'b0;
            special_value_r <= '0;
            opb             <= '0;
            acc_hi          <= '0;
            acc_lo          <= '0;
            rd_reg          <= '0;
        end else if (accept) begin
            counter         <= '0;
            op_code         <= alu_select[1:0];
            op_is_mul       <= sel_is_mul;
            neg_main        <= a_neg ^ b_neg;
            neg_rem         <= a_neg;
            special_r       <= is_special;
            special_value_r <= special_value;
            opb             <= mag_b;
            rd_reg          <= rd_in;
            if (sel_is_mul && (FAST_MUL != 0)) begin
                acc_hi <= fast_product[2*XLEN-1:XLEN];
                acc_lo <= fast_product[XLEN-1:0];
            end else begin
                acc_hi <= '0;
                acc_lo <= mag_a;
            end
        end else if (state == ST_BUSY) begin
            counter <= counter + 1'b1;
            acc_hi  <= hi_step;
            acc_lo  <= lo_step;
        end
    end

    // A flush during DONE squashes the completing op, so the held copy keeps
    // the previously completed result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_hold <= '0;
            rd_hold     <= '0;
        end else if ((state == ST_DONE) && !flush) begin
            result_hold <= final_value;
            rd_hold     <= rd_reg;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy         = (state != ST_IDLE);
    assign result_valid = (state == ST_DONE);
    assign result       = result_valid ? final_value : result_hold;
    assign rd_out       = result_valid ? rd_reg : rd_hold;

    // reset_n gates stall so a start arriving during reset cannot freeze
    // the pipeline.
    assign stall = reset_n & ~flush & (accept | (state == ST_BUSY));

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Self-checking bench for muldiv_sequencer: a directed vector table, random
// ops checked against an arithmetic reference model, and hand-written
// sequences for reset, flush and ignored starts.
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;

    localparam logic [4:0] OP_MUL    = 5'b00100;
    localparam logic [4:0] OP_MULH   = 5'b00101;
    localparam logic [4:0] OP_MULHU  = 5'b00110;
    localparam logic [4:0] OP_MULHSU = 5'b00111;
    localparam logic [4:0] OP_DIV    = 5'b01000;
    localparam logic [4:0] OP_DIVU   = 5'b01001;
    localparam logic [4:0] OP_REM    = 5'b01010;
    localparam logic [4:0] OP_REMU   = 5'b01011;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [4:0]  alu_select;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  rd_in;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [4:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_result;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    muldiv_sequencer #(.XLEN(32), .FAST_MUL(0)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .alu_select   (alu_select),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .rd_in        (rd_in),
        .flush        (flush),
        .stall        (stall),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .rd_out       (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain 64-bit arithmetic on the operands.
    function automatic logic [31:0] refModel(input logic [4:0] sel,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        longint      p;
        logic [63:0] pu;
        int          ia;
        int          ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'h0, b});
        ia = a;
        ib = b;
        case (sel)
            OP_MUL:    begin p = sa * sb; return p[31:0]; end
            OP_MULH:   begin p = sa * sb; return p[63:32]; end
            OP_MULHSU: begin p = sa * ub; return p[63:32]; end
            OP_MULHU:  begin pu = {32'h0, a} * {32'h0, b}; return pu[63:32]; end
            OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return ia / ib;
            end
            OP_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            OP_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            OP_REMU: begin
                if (b == 0) return a;
                return a % b;
            end
            default: return 32'h0;
        endcase
    endfunction

    function automatic int refLatency(input logic [4:0] sel,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
        bit is_div;
        bit is_signed_div;
        is_div        = (sel == OP_DIV) || (sel == OP_DIVU) || (sel == OP_REM) || (sel == OP_REMU);
        is_signed_div = (sel == OP_DIV) || (sel == OP_REM);
        if (is_div && (b == 0)) return 1;
        if (is_signed_div && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Issues one op and follows it to completion (bounded wait).
    task automatic applyStimulus(input logic [4:0] sel, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd,
                                 output logic [31:0] res, output logic [4:0] rdo,
                                 output int lat, output int stall_cnt,
                                 output logic stall_done, output logic busy_after);
        @(posedge clk); #1;
        start      = 1'b1;
        alu_select = sel;
        operand_a  = a;
        operand_b  = b;
        rd_in      = rd;
        #1;
        stall_cnt = stall ? 1 : 0;
        @(posedge clk); #1;
        start      = 1'b0;
        alu_select = 5'd0;
        operand_a  = $urandom;
        operand_b  = $urandom;
        rd_in      = 5'd0;
        lat = 1;
        while (!result_valid && lat < 60) begin
            if (stall) stall_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        res        = result;
        rdo        = rd_out;
        stall_done = stall;
        @(posedge clk); #1;
        busy_after = busy;
    endtask

    task automatic runOp(input string name, input logic [4:0] sel,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_result,
                         input int exp_lat);
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        int          stall_cnt;
        logic        stall_done;
        logic        busy_after;
        applyStimulus(sel, a, b, rd, res, rdo, lat, stall_cnt, stall_done, busy_after);
        checkOutput({name, " result"}, res, exp_result);
        checkOutput({name, " rd_out"}, {27'h0, rdo}, {27'h0, rd});
        checkOutput({name, " latency"}, lat, exp_lat);
        checkOutput({name, " stall cycles"}, stall_cnt, exp_lat);
        checkOutput({name, " stall in done"}, {31'h0, stall_done}, 32'h0);
        checkOutput({name, " busy after done"}, {31'h0, busy_after}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          seen;
        logic [4:0]  rsel;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  bad_codes[4];

        vecs[0]  = '{"MUL 7*-3",        OP_MUL,    32'h7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{"MULH min*min",    OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
        vecs[2]  = '{"MULHU -1*-1",     OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[3]  = '{"MULHSU -1*-1",    OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        vecs[4]  = '{"DIV -7/2",        OP_DIV,    32'hFFFF_FFF9,  32'h2,         32'hFFFF_FFFD, 33};
        vecs[5]  = '{"REM -7,2",        OP_REM,    32'hFFFF_FFF9,  32'h2,         32'hFFFF_FFFF, 33};
        vecs[6]  = '{"DIVU 100/7",      OP_DIVU,   32'd100,        32'd7,         32'd14,        33};
        vecs[7]  = '{"REMU 100,7",      OP_REMU,   32'd100,        32'd7,         32'd2,         33};
        vecs[8]  = '{"DIVU 100/0",      OP_DIVU,   32'd100,        32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{"REMU 100,0",      OP_REMU,   32'd100,        32'd0,         32'd100,       1};
        vecs[10] = '{"DIV overflow",    OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{"REM overflow",    OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1};

        // Reset state, with a valid start held during reset
        reset_n    = 1'b0;
        start      = 1'b1;
        flush      = 1'b0;
        alu_select = OP_MUL;
        operand_a  = 32'd3;
        operand_b  = 32'd4;
        rd_in      = 5'd1;
        #12;
        checkOutput("reset stall", {31'h0, stall}, 32'h0);
        checkOutput("reset busy", {31'h0, busy}, 32'h0);
        checkOutput("reset result_valid", {31'h0, result_valid}, 32'h0);
        checkOutput("reset result", result, 32'h0);
        checkOutput("reset rd_out", {27'h0, rd_out}, 32'h0);
        start = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("post-reset busy", {31'h0, busy}, 32'h0);

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            runOp(vecs[i].name, vecs[i].sel, vecs[i].a, vecs[i].b, 5'(i + 1),
                  vecs[i].exp_result, vecs[i].exp_lat);
        end

        // Random ops against the reference model
        for (int i = 0; i < 40; i++) begin
            rsel = 5'(4 + $urandom_range(0, 7));
            ra   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 9))
                0:       rb = 32'h0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            runOp($sformatf("rand%0d sel=%b a=%h b=%h", i, rsel, ra, rb), rsel, ra, rb,
                  5'($urandom_range(1, 31)), refModel(rsel, ra, rb), refLatency(rsel, ra, rb));
        end

        // Start with non-M codes is ignored
        bad_codes[0] = 5'b00000;
        bad_codes[1] = 5'b00011;
        bad_codes[2] = 5'b01100;
        bad_codes[3] = 5'b11111;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            start      = 1'b1;
            alu_select = bad_codes[i];
            #1;
            checkOutput($sformatf("non-M %b stall", bad_codes[i]), {31'h0, stall}, 32'h0);
            @(posedge clk); #1;
            start = 1'b0;
            checkOutput($sformatf("non-M %b busy", bad_codes[i]), {31'h0, busy}, 32'h0);
        end

        // Flush in the same cycle as start is not accepted
        @(posedge clk); #1;
        start      = 1'b1;
        flush      = 1'b1;
        alu_select = OP_DIVU;
        operand_a  = 32'd9;
        operand_b  = 32'd3;
        #1;
        checkOutput("flush+start stall", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        checkOutput("flush+start busy", {31'h0, busy}, 32'h0);

        // Flush at BUSY cycle 10, then no result pulse
        @(posedge clk); #1;
        start      = 1'b1;
        alu_select = OP_DIVU;
        operand_a  = 32'd1000;
        operand_b  = 32'd3;
        rd_in      = 5'd12;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        checkOutput("busy before flush", {31'h0, busy}, 32'h1);
        flush = 1'b1;
        #1;
        checkOutput("stall during flush", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        flush = 1'b0;
        checkOutput("busy after flush", {31'h0, busy}, 32'h0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (result_valid) seen++;
            @(posedge clk); #1;
        end
        checkOutput("result pulses after flush", seen, 0);

        runOp("DIVU 9/3 after flush", OP_DIVU, 32'd9, 32'd3, 5'd7, 32'd3, 33);
        repeat (3) begin
            @(posedge clk); #1;
        end
        checkOutput("hold result", result, 32'd3);
        checkOutput("hold rd_out", {27'h0, rd_out}, 32'd7);
        checkOutput("hold result_valid", {31'h0, result_valid}, 32'h0);

        // Asynchronous reset in the middle of BUSY
        @(posedge clk); #1;
        start      = 1'b1;
        alu_select = OP_MUL;
        operand_a  = 32'd5;
        operand_b  = 32'd6;
        rd_in      = 5'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid-busy reset busy", {31'h0, busy}, 32'h0);
        checkOutput("mid-busy reset result", result, 32'h0);
        checkOutput("mid-busy reset rd_out", {27'h0, rd_out}, 32'h0);
        checkOutput("mid-busy reset stall", {31'h0, stall}, 32'h0);
        checkOutput("mid-busy reset result_valid", {31'h0, result_valid}, 32'h0);
        #3;
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (result_valid) seen++;
        end
        checkOutput("result pulses after reset", seen, 0);
        checkOutput("busy after reset release", {31'h0, busy}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
